// File: rtl/core_pkg.sv
// Shared types and defaults for the fetch front end of the pipelined core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pkg;

    typedef enum logic {
        FS_IDLE = 1'b0,
        FS_RUN  = 1'b1
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;
    localparam int          DEFAULT_FQ_DEPTH = 4;

    // Queue entry at the default 32-bit address/instruction widths.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, used to buffer fetched {pc, instr} pairs.
// Latency: a write at edge N is visible on rdData after edge N (registered head, no bypass).
// Backpressure: writes are dropped while full and reads while empty; flush empties the queue in one cycle.
//
// Ports: clk, rst (async active-high), flush, wrEn/wrData, rdEn/rdData,
//        full, empty, count (occupied entries).
module fetch_fifo
    import core_pkg::*;
#(
    parameter int  DEPTH = DEFAULT_FQ_DEPTH,
    parameter type T     = fq_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wrEn,
    input  T                         wrData,
    input  logic                     rdEn,
    output T                         rdData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0] wrPtr;
    logic [AW:0] rdPtr;
    T            mem [DEPTH];

    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign count  = wrPtr - rdPtr;
    assign rdData = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (wrEn && !full) begin
                mem[wrPtr[AW-1:0]] <= wrData;
                wrPtr              <= wrPtr + 1'b1;
            end
            if (rdEn && !empty) begin
                rdPtr <= rdPtr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch unit: owns the PC, runs the start/restart FSM and queues {pc, instr} pairs for decode.
// Latency: fetched instruction reaches dec_* one edge after fetch; first redirected instruction two edges after redirect.
// Backpressure: dec_valid/dec_ready handshake; fetch stalls while the queue is full (no full-bypass).
//
// Ports: clk, rst (async active-high), trigger (start/restart), imem_addr/imem_instr
//        (combinational instruction memory), redirect_valid/redirect_pc, dec_valid/dec_ready/
//        dec_instr/dec_pc (decode side), fq_count, running, perf_fetch_cnt, perf_stall_cnt.
// Optional: define FETCH_PERF_CNT_EN to build the saturating perf counters; otherwise they read 0.
module fetch_queue_unit
    import core_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    OFFSET      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(DEFAULT_RESET_PC),
    parameter int                    FQ_DEPTH    = DEFAULT_FQ_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         trigger,
    output logic [ADDR_WIDTH-1:0]        imem_addr,
    input  logic [INSTR_WIDTH-1:0]       imem_instr,
    input  logic                         redirect_valid,
    input  logic [ADDR_WIDTH-1:0]        redirect_pc,
    output logic                         dec_valid,
    input  logic                         dec_ready,
    output logic [INSTR_WIDTH-1:0]       dec_instr,
    output logic [ADDR_WIDTH-1:0]        dec_pc,
    output logic [$clog2(FQ_DEPTH):0]    fq_count,
    output logic                         running,
    output logic [31:0]                  perf_fetch_cnt,
    output logic [31:0]                  perf_stall_cnt
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    fetch_state_t          state;
    fetch_state_t          nextState;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  fqFull;
    logic                  fqEmpty;
    logic                  doFetch;
    logic                  doFlush;
    logic                  doDequeue;
    entry_t                wrEntry;
    entry_t                headEntry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FS_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Restart and redirect both flush; restart wins on the PC value below.
    always_comb begin
        nextState = state;
        doFetch   = 1'b0;
        doFlush   = 1'b0;
        case (state)
            FS_IDLE: begin
                if (trigger) begin
                    nextState = FS_RUN;
                end
            end
            FS_RUN: begin
                if (trigger || redirect_valid) begin
                    doFlush = 1'b1;
                end else begin
                    doFetch = !fqFull;
                end
            end
            default: nextState = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (state == FS_RUN) begin
            if (trigger) begin
                pc <= RESET_PC;
            end else if (redirect_valid) begin
                pc <= redirect_pc;
            end else if (doFetch) begin
                pc <= pc + ADDR_WIDTH'(OFFSET);
            end
        end
    end

    assign imem_addr     = pc;
    assign running       = (state == FS_RUN);
    assign wrEntry.pc    = pc;
    assign wrEntry.instr = imem_instr;
    assign doDequeue     = dec_valid && dec_ready && !doFlush;

    fetch_fifo #(
        .DEPTH (FQ_DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .flush  (doFlush),
        .wrEn   (doFetch),
        .wrData (wrEntry),
        .rdEn   (doDequeue),
        .rdData (headEntry),
        .full   (fqFull),
        .empty  (fqEmpty),
        .count  (fq_count)
    );

    assign dec_valid = !fqEmpty;
    assign dec_pc    = headEntry.pc;
    assign dec_instr = headEntry.instr;

`ifdef FETCH_PERF_CNT_EN
    logic stallCycle;
    assign stallCycle = running && fqFull && !redirect_valid && !trigger;

    // Counters survive restart; only rst clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (doFetch && (perf_fetch_cnt != '1)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (stallCycle && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`else
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit with a queue-based reference scoreboard.
// Latency: n/a.
// Backpressure: dec_ready driven directly and randomly by the bench.
module tb_fetch_queue_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        trigger;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [2:0]  fq_count;
    logic        running;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imemModel(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    assign imem_instr = imemModel(imem_addr);

    fetch_queue_unit dut (
        .clk            (clk),
        .rst            (rst),
        .trigger        (trigger),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .fq_count       (fq_count),
        .running        (running),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    // ---------------- reference scoreboard ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sbEntry_t;

    sbEntry_t    sbQ[$];
    bit          mRun;
    logic [31:0] mPc;
    logic [31:0] mFetchCnt;
    logic [31:0] mStallCnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sbQ.delete();
            mRun      = 1'b0;
            mPc       = 32'h0;
            mFetchCnt = 32'h0;
            mStallCnt = 32'h0;
        end else if (!mRun) begin
            if (trigger) mRun = 1'b1;
        end else if (trigger) begin
            sbQ.delete();
            mPc = 32'h0;
        end else if (redirect_valid) begin
            sbQ.delete();
            mPc = redirect_pc;
        end else begin
            bit wasFull;
            wasFull = (sbQ.size() == DEPTH);
            if (sbQ.size() > 0 && dec_ready) void'(sbQ.pop_front());
            if (!wasFull) begin
                sbEntry_t e;
                e.pc    = mPc;
                e.instr = imemModel(mPc);
                sbQ.push_back(e);
                mPc = mPc + 32'd4;
                mFetchCnt++;
            end else begin
                mStallCnt++;
            end
        end
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkOutputs();
        logic [31:0] expFetch;
        logic [31:0] expStall;
`ifdef FETCH_PERF_CNT_EN
        expFetch = mFetchCnt;
        expStall = mStallCnt;
`else
        expFetch = 32'h0;
        expStall = 32'h0;
`endif
        checkVal("imem_addr", 64'(imem_addr), 64'(mPc));
        checkVal("running", 64'(running), 64'(mRun));
        checkVal("fq_count", 64'(fq_count), 64'(sbQ.size()));
        checkVal("dec_valid", 64'(dec_valid), 64'(sbQ.size() > 0));
        if (sbQ.size() > 0) begin
            checkVal("dec_pc", 64'(dec_pc), 64'(sbQ[0].pc));
            checkVal("dec_instr", 64'(dec_instr), 64'(sbQ[0].instr));
        end
        checkVal("perf_fetch", 64'(perf_fetch_cnt), 64'(expFetch));
        checkVal("perf_stall", 64'(perf_stall_cnt), 64'(expStall));
    endtask

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutputs();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        trigger        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b0;
        #12;
        checkOutputs();
        checkVal("rst_dec_pc", 64'(dec_pc), 64'h0);
        checkVal("rst_dec_instr", 64'(dec_instr), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Idle with trigger low: nothing happens.
        cycle(5);
        checkVal("idle_addr", 64'(imem_addr), 64'h0);
        checkVal("idle_running", 64'(running), 64'h0);

        // Start, then fill the queue with decode stalled.
        trigger = 1'b1;
        cycle(1);
        trigger = 1'b0;
        checkVal("start_running", 64'(running), 64'h1);
        checkVal("start_empty", 64'(dec_valid), 64'h0);
        cycle(1);
        checkVal("first_pc", 64'(dec_pc), 64'h0);
        cycle(3);
        checkVal("full_count", 64'(fq_count), 64'h4);
        checkVal("full_pc_hold", 64'(imem_addr), 64'h10);
        cycle(3);

        // One dequeue from a full queue: no enqueue that cycle, then refill.
        dec_ready = 1'b1;
        cycle(1);
        dec_ready = 1'b0;
        checkVal("deq_count", 64'(fq_count), 64'h3);
        checkVal("deq_head", 64'(dec_pc), 64'h4);
        cycle(1);
        checkVal("refill_count", 64'(fq_count), 64'h4);

        // Drop to 3 entries, then redirect (dequeue handshake ignored).
        dec_ready = 1'b1;
        cycle(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cycle(1);
        redirect_valid = 1'b0;
        dec_ready      = 1'b0;
        checkVal("redir_count", 64'(fq_count), 64'h0);
        checkVal("redir_valid", 64'(dec_valid), 64'h0);
        checkVal("redir_addr", 64'(imem_addr), 64'h100);
        cycle(1);
        checkVal("redir_head", 64'(dec_pc), 64'h100);

        // Restart overrides a simultaneous redirect.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        trigger        = 1'b1;
        cycle(1);
        redirect_valid = 1'b0;
        trigger        = 1'b0;
        checkVal("restart_addr", 64'(imem_addr), 64'h0);
        checkVal("restart_count", 64'(fq_count), 64'h0);
        checkVal("restart_running", 64'(running), 64'h1);

        // PC wraps modulo 2^32.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cycle(1);
        redirect_valid = 1'b0;
        cycle(1);
        checkVal("wrap_addr", 64'(imem_addr), 64'h0);
        checkVal("wrap_head", 64'(dec_pc), 64'hFFFF_FFFC);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 300; i++) begin
            dec_ready      = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = {$urandom_range(0, 16'hFFFF), 14'h0, 2'b00};
            trigger        = ($urandom_range(0, 40) == 0);
            cycle(1);
        end
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        trigger        = 1'b1;
        cycle(1);
        trigger = 1'b0;
        cycle(2);
        checkVal("pre_rst_count", 64'(fq_count), 64'h2);

        // Asynchronous reset mid-RUN.
        #2;
        rst = 1'b1;
        #1;
        checkVal("arst_valid", 64'(dec_valid), 64'h0);
        checkVal("arst_running", 64'(running), 64'h0);
        checkVal("arst_count", 64'(fq_count), 64'h0);
        checkVal("arst_addr", 64'(imem_addr), 64'h0);
        checkVal("arst_perf_fetch", 64'(perf_fetch_cnt), 64'h0);
        checkVal("arst_perf_stall", 64'(perf_stall_cnt), 64'h0);
        checkOutputs();
        @(negedge clk);
        rst = 1'b0;
        cycle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
